// File: rtl/shift_add_mult_4bit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared definitions for the 4x4 shift-and-add multiplier:
//             operand width, step count and controller state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

  localparam int MULT_W     = 4;
  localparam int MULT_STEPS = 4;
  localparam int CNT_W      = 2;

  // 2'b11 is unused; the controller treats it as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_e;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/shift_add_mult_4bit_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult_4bit_if
//  Purpose  : Start/busy/done handshake bundle for the 4x4 multiplier.
//  Signals  : start   - request a multiply (master -> slave)
//             a, b    - unsigned operands (master -> slave)
//             busy    - multiply in progress (slave -> master)
//             done    - one-cycle result-valid pulse (slave -> master)
//             product - registered 8-bit result (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface shift_add_mult_4bit_if;
  import mult_pkg::*;

  logic                  start;
  logic [MULT_W-1:0]     a;
  logic [MULT_W-1:0]     b;
  logic                  busy;
  logic                  done;
  logic [2*MULT_W-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface : shift_add_mult_4bit_if
`default_nettype wire

// File: rtl/shift_add_mult_4bit_adder.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_4bit
//  Purpose  : 4-bit ripple-carry adder used as the multiplier's add stage.
//  Ports    : a, b  in  4  addends
//             cin   in  1  carry in
//             sum   out 4  sum bits
//             cout  out 1  carry out
//  Revision : 1.0  initial release
// ============================================================================
module full_adder_4bit (
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  input  wire logic       cin,
  output logic      [3:0] sum,
  output logic            cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule : full_adder_4bit
`default_nettype wire

// File: rtl/shift_add_mult_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult_4bit
//  Purpose  : Sequential 4x4 unsigned multiplier. Each RUN cycle adds the
//             multiplicand (gated by the multiplier LSB) to the high partial
//             product and shifts {carry,sum,q} right by one. 4 steps per
//             result; product is registered and held until the next result.
//  Ports    : clk    in  1  rising-edge clock
//             rst_n  in  1  asynchronous active-low reset
//             bus    slave modport of shift_add_mult_4bit_if
//                    (start, a, b in; busy, done, product out)
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_mult_4bit
  import mult_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  shift_add_mult_4bit_if.slave   bus
);

  mult_state_e           state_q, state_d;
  logic [MULT_W-1:0]     m_q, m_d;
  logic [MULT_W-1:0]     q_q, q_d;
  logic [MULT_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*MULT_W-1:0]   product_q, product_d;

  logic [MULT_W-1:0]     add_b;
  logic [MULT_W-1:0]     add_sum;
  logic                  add_cout;
  logic [2*MULT_W:0]     shifted;

  // Add stage: acc + (q[0] ? m : 0), no carry in.
  assign add_b = q_q[0] ? m_q : '0;

  full_adder_4bit u_add (
    .a    (acc_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // 9-bit right shift of {carry,sum,q}; the bit falling off the bottom
  // (q[0]) has already been consumed by this step.
  assign shifted = {add_cout, add_sum, q_q};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          m_d     = bus.a;
          q_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        acc_d = shifted[2*MULT_W:MULT_W+1];
        q_d   = shifted[MULT_W:1];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CNT_W'(MULT_STEPS - 1)) begin
          product_d = shifted[2*MULT_W:1];
          state_d   = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Status decoded straight from registered state.
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule : shift_add_mult_4bit
`default_nettype wire

// File: tb/tb_shift_add_mult_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mult_4bit
//  Purpose  : Self-checking bench for shift_add_mult_4bit. Stimulus pushes
//             the expected product and accept cycle into a scoreboard; a
//             monitor pops and compares on every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_add_mult_4bit;

  typedef struct {
    logic [7:0] p;
    int         c;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;
  int   done_cnt;
  exp_t sb_q[$];

  shift_add_mult_4bit_if bus ();

  shift_add_mult_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("product", int'(bus.product), int'(e.p));
        check("latency", cyc - e.c, 4);
      end
    end
  end

  task automatic issue(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] exp_p);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_;
    @(posedge clk);
    #1;
    e.p = exp_p;
    e.c = cyc;
    sb_q.push_back(e);
    bus.start = 1'b0;
    bus.a     = 4'($urandom);
    bus.b     = 4'($urandom);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int d0;
    tests     = 0;
    fails     = 0;
    done_cnt  = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 4'h0;
    bus.b     = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_product", int'(bus.product), 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // F*F with busy window check
    issue(4'hF, 4'hF, 8'hE1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_run", int'({bus.busy, bus.done}), 2'b10);
    end
    @(negedge clk);
    check("busy_at_done", int'({bus.busy, bus.done}), 2'b01);
    wait_drain(10);

    issue(4'h7, 4'h3, 8'h15);  wait_drain(10);
    issue(4'h0, 4'h9, 8'h00);  wait_drain(10);
    issue(4'h1, 4'hF, 8'h0F);  wait_drain(10);

    // Start pulse during RUN must be ignored
    d0 = done_cnt;
    issue(4'h5, 4'h6, 8'h1E);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'hF;
    bus.b     = 4'hF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_drain(10);
    repeat (8) @(negedge clk);
    check("start_in_run_done_count", done_cnt - d0, 1);

    // Held start: accepts at E0, E5, E10
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'h3;
    bus.b     = 4'h4;
    fork
      begin
        exp_t e;
        @(posedge clk);
        #1;
        e.p = 8'h0C; e.c = cyc; sb_q.push_back(e);
        repeat (2) begin
          repeat (5) @(posedge clk);
          #1;
          e.p = 8'h0C; e.c = cyc; sb_q.push_back(e);
        end
        bus.start = 1'b0;
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 14; i++) begin
          @(negedge clk);
          check("held_busy_xor_done", int'(bus.busy ^ bus.done), 1);
        end
      end
    join
    wait_drain(10);
    repeat (3) @(negedge clk);
    check("held_done_count", done_cnt - d0, 3);

    // Asynchronous reset mid-run
    issue(4'hF, 4'hF, 8'hE1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_product", int'(bus.product), 8'h00);
    sb_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle_busy", int'(bus.busy), 0);

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        issue(4'(ia), 4'(ib), 8'(ia * ib));
        wait_drain(10);
      end
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_shift_add_mult_4bit
`default_nettype wire
